dev_regs_arbiter: RTL and testbench

DEV_REGS_ARBITER -- requirements
Module: dev_regs_arbiter

---
 rtl/dev_regs_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/dev_regs_arbiter.sv | 118 +++++++++++
 tb/tb_dev_regs_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dev_regs_pkg.sv
// Shared types and widths for the register-bank arbiter.
// Latency: n/a. Backpressure: n/a.
// Holds FSM encodings, address/data widths and the default top offset.
package dev_regs_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] MAX_ADDR_DEF = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie, the requester not granted last wins.
// Latency: combinational. Backpressure: grant only while update is high.
// The pointer is the index of the last granted requester.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  input  logic       update,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (update) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = pointer ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dev_regs_arbiter.sv
// Arbitrates two requesters onto a single register bank port.
// Latency: write 2, read 3, out-of-range 1 cycle from the IDLE cycle seeing req to ack.
// Backpressure: requesters hold their command until ack; one transaction in flight.
module dev_regs_arbiter
  import dev_regs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [7:0]        req_addr,
  input  logic [15:0]       req_wdata,
  output logic [1:0]        ack,
  output logic              ack_err,
  output logic [DATA_W-1:0] ack_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] dev_address,
  output logic              dev_write_en,
  output logic              dev_read_en,
  output logic [DATA_W-1:0] dev_data_in,
  input  logic [DATA_W-1:0] dev_read_data
);

  state_t              state;
  logic                ptr;
  logic                win_q;
  logic                we_q;
  logic [1:0]          gnt;
  logic                sel;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arb2 u_rr (
    .req     (req),
    .pointer (ptr),
    .update  (state == ST_IDLE),
    .grant   (gnt)
  );

  assign sel       = gnt[1];
  assign sel_we    = req_we[sel];
  assign sel_addr  = sel ? req_addr[7:4]   : req_addr[3:0];
  assign sel_wdata = sel ? req_wdata[15:8] : req_wdata[7:0];

  // All outputs are registered; each transition loads the values for the next state.
  always_ff @(posedge clk) begin
    if (resetb) begin
      state        <= ST_IDLE;
      ptr          <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      ack          <= 2'b00;
      ack_err      <= 1'b0;
      ack_rdata    <= '0;
      busy         <= 1'b0;
      dev_address  <= '0;
      dev_write_en <= 1'b0;
      dev_read_en  <= 1'b0;
      dev_data_in  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            win_q <= sel;
            we_q  <= sel_we;
            busy  <= 1'b1;
            if (sel_addr > MAX_ADDR) begin
              state     <= ST_DONE;
              ack       <= onehot2(sel);
              ack_err   <= 1'b1;
              ack_rdata <= '0;
            end else begin
              state        <= ST_ISSUE;
              dev_address  <= sel_addr;
              dev_write_en <= sel_we;
              dev_read_en  <= ~sel_we;
              dev_data_in  <= sel_wdata;
            end
          end
        end
        ST_ISSUE: begin
          dev_address  <= '0;
          dev_write_en <= 1'b0;
          dev_read_en  <= 1'b0;
          dev_data_in  <= '0;
          if (we_q) begin
            state     <= ST_DONE;
            ack       <= onehot2(win_q);
            ack_err   <= 1'b0;
            ack_rdata <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Bank registers its read data, so it is valid in this cycle.
          state     <= ST_DONE;
          ack       <= onehot2(win_q);
          ack_err   <= 1'b0;
          ack_rdata <= dev_read_data;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ptr       <= win_q;
          ack       <= 2'b00;
          ack_err   <= 1'b0;
          ack_rdata <= '0;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_regs_arbiter.sv
// Scoreboarded bench for dev_regs_arbiter with a behavioural register bank.
// Expected acks and bank strobes are queued at issue time and popped by a monitor.
module tb_dev_regs_arbiter;

  typedef struct {
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } ack_exp_t;

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } stb_exp_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  ack;
  logic        ack_err;
  logic [7:0]  ack_rdata;
  logic        busy;
  logic [3:0]  dev_address;
  logic        dev_write_en;
  logic        dev_read_en;
  logic [7:0]  dev_data_in;
  logic [7:0]  dev_read_data;

  logic [7:0]  bank [0:15];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ack_exp_t ackq[$];
  stb_exp_t stbq[$];
  ack_exp_t ea;
  stb_exp_t es;

  dev_regs_arbiter dut (
    .clk           (clk),
    .resetb        (resetb),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .ack           (ack),
    .ack_err       (ack_err),
    .ack_rdata     (ack_rdata),
    .busy          (busy),
    .dev_address   (dev_address),
    .dev_write_en  (dev_write_en),
    .dev_read_en   (dev_read_en),
    .dev_data_in   (dev_data_in),
    .dev_read_data (dev_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dev_write_en) bank[dev_address] <= dev_data_in;
    if (dev_read_en)  dev_read_data <= bank[dev_address];
  end

  always @(negedge clk) begin
    if (!resetb) begin
      if (ack != 2'b00) begin
        checks++;
        if (ackq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got ack=%b err=%b rdata=%h cyc=%0d, required no ack",
                   ack, ack_err, ack_rdata, cyc);
        end else begin
          ea = ackq.pop_front();
          if (ack !== ea.ack || ack_err !== ea.err || ack_rdata !== ea.rdata || cyc != ea.cyc) begin
            errors++;
            $display("FAIL ack_resp: got ack=%b err=%b rdata=%h cyc=%0d, required ack=%b err=%b rdata=%h cyc=%0d",
                     ack, ack_err, ack_rdata, cyc, ea.ack, ea.err, ea.rdata, ea.cyc);
          end
        end
      end
      if (dev_write_en || dev_read_en) begin
        checks++;
        if (stbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got we=%b re=%b addr=%h cyc=%0d, required no strobe",
                   dev_write_en, dev_read_en, dev_address, cyc);
        end else begin
          es = stbq.pop_front();
          if (dev_write_en !== es.we || dev_read_en !== es.re || dev_address !== es.addr ||
              dev_data_in !== es.data || cyc != es.cyc) begin
            errors++;
            $display("FAIL bank_strobe: got we=%b re=%b addr=%h data=%h cyc=%0d, required we=%b re=%b addr=%h data=%h cyc=%0d",
                     dev_write_en, dev_read_en, dev_address, dev_data_in, cyc,
                     es.we, es.re, es.addr, es.data, es.cyc);
          end
        end
      end else begin
        checks++;
        if (dev_address !== 4'h0 || dev_data_in !== 8'h00) begin
          errors++;
          $display("FAIL idle_dev_bus: got addr=%h data=%h cyc=%0d, required 0/00",
                   dev_address, dev_data_in, cyc);
        end
      end
    end
  end

  // Called #1 after a rising edge with the DUT in IDLE; leaves it in IDLE with req dropped.
  task automatic run_one(input int n, input logic we, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_err);
    int c0;
    int lat;
    c0  = cyc;
    lat = exp_err ? 1 : (we ? 2 : 3);
    req_we[n] = we;
    if (n == 1) begin
      req_addr[7:4]   = a;
      req_wdata[15:8] = d;
    end else begin
      req_addr[3:0]  = a;
      req_wdata[7:0] = d;
    end
    req[n] = 1'b1;
    ackq.push_back(ack_exp_t'{(n == 1) ? 2'b10 : 2'b01, exp_err, exp_rd, c0 + lat});
    if (!exp_err) stbq.push_back(stb_exp_t'{we, ~we, a, d, c0 + 1});
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_active: got %b, required 1", busy);
    end
    repeat (lat) @(posedge clk);
    #1;
    req[n] = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b0;

    checks++;
    if (ack !== 2'b00 || ack_err !== 1'b0 || ack_rdata !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got ack=%b err=%b rdata=%h busy=%b, required all 0",
               ack, ack_err, ack_rdata, busy);
    end
    checks++;
    if (dev_write_en !== 1'b0 || dev_read_en !== 1'b0 || dev_address !== 4'h0 || dev_data_in !== 8'h00) begin
      errors++;
      $display("FAIL reset_dev: got we=%b re=%b addr=%h data=%h, required all 0",
               dev_write_en, dev_read_en, dev_address, dev_data_in);
    end

    // Both requesters write and hold req: grants 0,1,0,1 every three cycles.
    c0 = cyc;
    req_we    = 2'b11;
    req_addr  = {4'd1, 4'd0};
    req_wdata = {8'h22, 8'h11};
    req       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ackq.push_back(ack_exp_t'{(k % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 8'h00, c0 + 2 + 3 * k});
      stbq.push_back(stb_exp_t'{1'b1, 1'b0, (k % 2 == 1) ? 4'd1 : 4'd0,
                                (k % 2 == 1) ? 8'h22 : 8'h11, c0 + 1 + 3 * k});
    end
    repeat (12) @(posedge clk);
    #1;
    req = 2'b00;

    run_one(0, 1'b1, 4'd2, 8'hA5, 8'h00, 1'b0);
    run_one(1, 1'b0, 4'd2, 8'h00, 8'hA5, 1'b0);
    run_one(0, 1'b0, 4'h9, 8'h00, 8'h00, 1'b1);
    run_one(1, 1'b1, 4'd3, 8'h3C, 8'h00, 1'b0);
    run_one(0, 1'b0, 4'd3, 8'h00, 8'h3C, 1'b0);
    run_one(1, 1'b1, 4'd4, 8'h77, 8'h00, 1'b1);
    run_one(0, 1'b0, 4'd0, 8'h00, 8'h11, 1'b0);

    // Reset while a read sits in WAIT: strobe happened, but no ack may follow.
    c0 = cyc;
    req_we[0]      = 1'b0;
    req_addr[3:0]  = 4'd1;
    req_wdata[7:0] = 8'h00;
    req[0]         = 1'b1;
    stbq.push_back(stb_exp_t'{1'b0, 1'b1, 4'd1, 8'h00, c0 + 1});
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    req    = 2'b00;
    @(posedge clk); #1;
    resetb = 1'b0;
    checks++;
    if (busy !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b ack=%b, required 0/00", busy, ack);
    end
    repeat (3) @(posedge clk);
    #1;
    run_one(1, 1'b0, 4'd1, 8'h00, 8'h22, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ackq.size() != 0 || stbq.size() != 0) begin
      errors++;
      $display("FAIL pending_expect: got %0d acks and %0d strobes outstanding, required 0/0",
               ackq.size(), stbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
